// File: rtl/sync_hs_tx_if.sv
// Handshake bundle for sync_hs_tx: upstream valid/ready word port plus the
// two-phase req/ack pair and held data word that go to the remote domain.
interface sync_hs_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  req_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack_in;

  // The transmitter side: takes upstream words, drives req/data, samples ack.
  modport master (
    input  in_valid,
    input  in_data,
    input  ack_in,
    output in_ready,
    output req_out,
    output data_out
  );

  // The environment side: upstream producer plus remote acknowledger.
  modport slave (
    output in_valid,
    output in_data,
    output ack_in,
    input  in_ready,
    input  req_out,
    input  data_out
  );
endinterface

// File: rtl/sync_hs_tx.sv
// Two-phase (toggle) request/acknowledge transmitter. A word accepted from
// upstream is held on data_out while req_out toggles; the transfer completes
// when the synchronised ack toggle matches req_out. Optional timeout flag and
// a protocol-error flag for acks that arrive with nothing outstanding.
module sync_hs_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_,
  sync_hs_tx_if.master      bus,
  output logic              done,
  output logic              timeout_err,
  output logic              proto_err
);

  // A zero timeout still needs a legal one-bit counter; it is simply never stepped.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic                  ack_p1, ack_p2, ack_sync;
  logic                  req_q, req_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  in_ready_q;
  logic                  done_nxt, timeout_nxt, proto_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;

  // Two-flop synchroniser: the only place ack_in is sampled.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ack_p1 <= 1'b0;
      ack_p2 <= 1'b0;
    end else begin
      ack_p1 <= bus.ack_in;
      ack_p2 <= ack_p1;
    end
  end

  assign ack_sync = ack_p2;

  // Next state: accept a word from IDLE, leave WAIT_ACK once ack matches req.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.in_valid)      state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_sync == req_q) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, sticky flags and timeout counter.
  always_comb begin
    req_nxt     = req_q;
    data_nxt    = data_q;
    done_nxt    = 1'b0;
    timeout_nxt = timeout_err;
    proto_nxt   = proto_err;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (ack_sync != req_q) proto_nxt = 1'b1;
        if (bus.in_valid) begin
          req_nxt  = ~req_q;
          data_nxt = bus.in_data;
          cnt_nxt  = '0;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_q) begin
          done_nxt = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt != CNT_MAX)) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == CNT_MAX) timeout_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      req_q       <= req_nxt;
      data_q      <= data_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      done        <= done_nxt;
      timeout_err <= timeout_nxt;
      proto_err   <= proto_nxt;
      cnt         <= cnt_nxt;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.req_out  = req_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_sync_hs_tx.sv
// Directed bench for sync_hs_tx: one DUT with the timeout disabled and one
// with a four-cycle timeout, sharing clock and reset.
module tb_sync_hs_tx;

  logic clk;
  logic reset_;
  logic done_a, terr_a, perr_a;
  logic done_t, terr_t, perr_t;
  int   checks;
  int   errors;
  logic exp_req;

  sync_hs_tx_if #(.DATA_WIDTH(8)) bus_a ();
  sync_hs_tx_if #(.DATA_WIDTH(8)) bus_t ();

  sync_hs_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(0)) u_dut_a (
    .clk(clk), .reset_(reset_), .bus(bus_a),
    .done(done_a), .timeout_err(terr_a), .proto_err(perr_a)
  );

  sync_hs_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) u_dut_t (
    .clk(clk), .reset_(reset_), .bus(bus_t),
    .done(done_t), .timeout_err(terr_t), .proto_err(perr_t)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.ack_in = 1'b0;
    bus_t.in_valid = 1'b0; bus_t.in_data = 8'h00; bus_t.ack_in = 1'b0;
    reset_ = 1'b0;
    tick(2);
    reset_ = 1'b1;
    tick(1);
    exp_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_ = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.ack_in = 1'b0;
    bus_t.in_valid = 1'b0; bus_t.in_data = 8'h00; bus_t.ack_in = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0h exp 1", bus_a.in_ready); end
    checks++; if (bus_a.req_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %0h exp 0", bus_a.req_out); end
    checks++; if (bus_a.data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %0h exp 0", bus_a.data_out); end
    checks++; if ({done_a, terr_a, perr_a} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %0b exp 000", {done_a, terr_a, perr_a}); end
    tick(2);
    reset_ = 1'b1;
    tick(1);
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %0h exp 1", bus_a.in_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA5;
    tick(1);
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.req_out !== 1'b1) begin errors++; $display("[TB] FAIL single_req got %0h exp 1", bus_a.req_out); end
    checks++; if (bus_a.data_out !== 8'hA5) begin errors++; $display("[TB] FAIL single_data got %0h exp a5", bus_a.data_out); end
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %0h exp 0", bus_a.in_ready); end
    tick(2);
    bus_a.ack_in = 1'b1;
    tick(2);
    checks++; if ({done_a, bus_a.in_ready} !== 2'b00) begin errors++; $display("[TB] FAIL single_early_done got %0b exp 00", {done_a, bus_a.in_ready}); end
    tick(1);
    checks++; if ({done_a, bus_a.in_ready} !== 2'b11) begin errors++; $display("[TB] FAIL single_done got %0b exp 11", {done_a, bus_a.in_ready}); end
    tick(1);
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width got %0h exp 0", done_a); end
    checks++; if ({terr_a, perr_a} !== 2'b00) begin errors++; $display("[TB] FAIL single_errs got %0b exp 00", {terr_a, perr_a}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int toggles;
    int dones;
    logic prev_req;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    toggles = 0; dones = 0;
    apply_reset();
    prev_req = bus_a.req_out;
    bus_a.in_valid = 1'b1; bus_a.in_data = words[0];
    for (int i = 0; i < 3; i++) begin
      tick(1);
      exp_req = ~exp_req;
      if (bus_a.req_out !== prev_req) toggles++;
      prev_req = bus_a.req_out;
      bus_a.in_valid = 1'b0;
      checks++; if (bus_a.req_out !== exp_req) begin errors++; $display("[TB] FAIL b2b_req[%0d] got %0h exp %0h", i, bus_a.req_out, exp_req); end
      checks++; if (bus_a.data_out !== words[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d] got %0h exp %0h", i, bus_a.data_out, words[i]); end
      checks++; if ({done_a, bus_a.in_ready} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_capture[%0d] got %0b exp 00", i, {done_a, bus_a.in_ready}); end
      tick(4);
      bus_a.ack_in = exp_req;
      tick(3);
      if (done_a === 1'b1) dones++;
      checks++; if ({done_a, bus_a.in_ready} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_done[%0d] got %0b exp 11", i, {done_a, bus_a.in_ready}); end
      if (i < 2) begin
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = words[i+1];
      end
    end
    tick(1);
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_done got %0h exp 0", done_a); end
    checks++; if (toggles != 3) begin errors++; $display("[TB] FAIL b2b_toggles got %0d exp 3", toggles); end
    checks++; if (dones != 3) begin errors++; $display("[TB] FAIL b2b_dones got %0d exp 3", dones); end
    checks++; if ({terr_a, perr_a} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_errs got %0b exp 00", {terr_a, perr_a}); end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus_t.in_valid = 1'b1; bus_t.in_data = 8'h77;
    tick(1);
    bus_t.in_valid = 1'b0;
    checks++; if (bus_t.req_out !== 1'b1) begin errors++; $display("[TB] FAIL to_req got %0h exp 1", bus_t.req_out); end
    tick(3);
    checks++; if (terr_t !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %0h exp 0", terr_t); end
    tick(1);
    checks++; if (terr_t !== 1'b1) begin errors++; $display("[TB] FAIL to_set got %0h exp 1", terr_t); end
    tick(3);
    checks++; if ({bus_t.in_ready, bus_t.req_out, bus_t.data_out} !== {1'b0, 1'b1, 8'h77}) begin errors++; $display("[TB] FAIL to_hold got %0h exp 177", {bus_t.in_ready, bus_t.req_out, bus_t.data_out}); end
    bus_t.ack_in = 1'b1;
    tick(3);
    checks++; if ({done_t, bus_t.in_ready, terr_t} !== 3'b111) begin errors++; $display("[TB] FAIL to_late_done got %0b exp 111", {done_t, bus_t.in_ready, terr_t}); end
    tick(1);
    checks++; if ({done_t, terr_t, perr_t} !== 3'b010) begin errors++; $display("[TB] FAIL to_sticky got %0b exp 010", {done_t, terr_t, perr_t}); end
  endtask

  task automatic test_spurious_ack();
    apply_reset();
    bus_a.ack_in = 1'b1;
    tick(2);
    checks++; if (perr_a !== 1'b0) begin errors++; $display("[TB] FAIL proto_early got %0h exp 0", perr_a); end
    tick(1);
    checks++; if (perr_a !== 1'b1) begin errors++; $display("[TB] FAIL proto_set got %0h exp 1", perr_a); end
    checks++; if ({bus_a.in_ready, bus_a.req_out} !== 2'b10) begin errors++; $display("[TB] FAIL proto_idle got %0b exp 10", {bus_a.in_ready, bus_a.req_out}); end
    bus_a.ack_in = 1'b0;
    tick(4);
    checks++; if (perr_a !== 1'b1) begin errors++; $display("[TB] FAIL proto_sticky got %0h exp 1", perr_a); end
  endtask

  task automatic test_input_stability();
    apply_reset();
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h5A;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      bus_a.in_data  = 8'(8'hC0 + i * 8'h13);
      bus_a.in_valid = i[0];
      tick(1);
      checks++; if ({bus_a.req_out, bus_a.data_out} !== {1'b1, 8'h5A}) begin errors++; $display("[TB] FAIL stab_hold[%0d] got %0h exp 15a", i, {bus_a.req_out, bus_a.data_out}); end
    end
    bus_a.in_valid = 1'b0;
    bus_a.ack_in = 1'b1;
    tick(3);
    checks++; if (done_a !== 1'b1) begin errors++; $display("[TB] FAIL stab_done got %0h exp 1", done_a); end
    checks++; if (bus_a.data_out !== 8'h5A) begin errors++; $display("[TB] FAIL stab_after_done got %0h exp 5a", bus_a.data_out); end
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h3C;
    tick(1);
    bus_a.in_valid = 1'b0;
    checks++; if ({bus_a.req_out, bus_a.data_out} !== {1'b0, 8'h3C}) begin errors++; $display("[TB] FAIL stab_next got %0h exp 03c", {bus_a.req_out, bus_a.data_out}); end
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'hC3;
    bus_t.in_valid = 1'b1; bus_t.in_data = 8'h99;
    tick(1);
    bus_a.in_valid = 1'b0;
    bus_t.in_valid = 1'b0;
    tick(5);
    checks++; if ({bus_a.req_out, terr_t} !== 2'b11) begin errors++; $display("[TB] FAIL mid_setup got %0b exp 11", {bus_a.req_out, terr_t}); end
    #2 reset_ = 1'b0;
    bus_a.ack_in = 1'b0;
    bus_t.ack_in = 1'b0;
    #1;
    checks++; if ({bus_a.req_out, bus_a.in_ready, bus_a.data_out} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("[TB] FAIL mid_async_a got %0h exp 100", {bus_a.req_out, bus_a.in_ready, bus_a.data_out}); end
    checks++; if ({bus_t.req_out, bus_t.in_ready, bus_t.data_out} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("[TB] FAIL mid_async_t got %0h exp 100", {bus_t.req_out, bus_t.in_ready, bus_t.data_out}); end
    checks++; if ({done_a, terr_a, perr_a, done_t, terr_t, perr_t} !== 6'b0) begin errors++; $display("[TB] FAIL mid_flags got %0b exp 000000", {done_a, terr_a, perr_a, done_t, terr_t, perr_t}); end
    tick(1);
    reset_ = 1'b1;
    tick(3);
    checks++; if ({bus_a.in_ready, perr_a} !== 2'b10) begin errors++; $display("[TB] FAIL mid_resume got %0b exp 10", {bus_a.in_ready, perr_a}); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    checks  = 0;
    errors  = 0;
    exp_req = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_spurious_ack();
    test_input_stability();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_hs_tx.md
SYNC_HS_TX -- requirements
Module: sync_hs_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of transferred word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 0, meaning cycles in WAIT_ACK before timeout_err is set; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream word.
REQ-008 SHALL have port req_out  output  1  two-phase request toggle to the remote domain.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  held word for the remote domain.
REQ-010 SHALL have port ack_in  input  1  two-phase acknowledge toggle, asynchronous to clk.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a transfer is acknowledged.
REQ-012 SHALL have port timeout_err  output  1  sticky flag: ack not seen within TIMEOUT_CYCLES.
REQ-013 SHALL have port proto_err  output  1  sticky flag: ack toggled with no request outstanding.

Function
REQ-014 SHALL synchronise ack_in through two flops (ack_p1, ack_p2), both clocked by clk; ack_p2 is ack_sync, and no other logic samples ack_in.
REQ-015 SHALL implement states IDLE and WAIT_ACK, with all outputs registered.
REQ-016 SHALL assert in_ready exactly while in IDLE.
REQ-017 SHALL, on a clk edge with IDLE && in_valid, load data_out <= in_data, toggle req_out, and enter WAIT_ACK; in_ready is low from the next cycle.
REQ-018 SHALL hold data_out and req_out constant throughout WAIT_ACK; in_valid and in_data are ignored there.
REQ-019 SHALL, in WAIT_ACK, on the edge where ack_sync == req_out, return to IDLE and pulse done high for exactly one cycle; in_ready rises in that same cycle.
REQ-020 SHALL give a minimum latency of 3 clk edges from an ack_in toggle (meeting setup at edge K) to done/in_ready high (after edge K+2).
REQ-021 SHALL accept a new word on the first in_ready cycle, so back-to-back transfers are possible (done and the new capture can coincide).
REQ-022 SHALL, in IDLE, when ack_sync != req_out, set proto_err and remain in IDLE; in_ready is unaffected.
REQ-023 SHALL count WAIT_ACK cycles in a counter of width clog2(TIMEOUT_CYCLES+1), cleared on entry to WAIT_ACK; when it reaches TIMEOUT_CYCLES (if nonzero) it SHALL set timeout_err, saturate, and keep waiting for ack.
REQ-024 SHALL let a late ack after a timeout still complete the transfer normally (done pulse, return to IDLE); timeout_err stays set.
REQ-025 SHALL clear timeout_err and proto_err only by reset.
REQ-026 SHALL treat in_valid, in_data and ack_in with X-free behaviour in IDLE whenever in_valid is low.

Reset
REQ-027 SHALL, on reset_ low, asynchronously force: state IDLE, req_out 0, ack_p1/ack_p2 0, data_out 0, done 0, timeout_err 0, proto_err 0, counter 0; in_ready is 1 after reset.
REQ-028 SHALL resume on the first clk edge after reset_ deasserts; reset during WAIT_ACK abandons the transfer, and the remote side SHALL also be reset so that its ack returns to 0.

Verification
REQ-029 Single transfer: in_valid=1, in_data=8'hA5 in IDLE -> req_out 0->1, data_out=A5, in_ready=0; ack_in 0->1 before edge K -> done=1 and in_ready=1 after edge K+2.
REQ-030 Back-to-back: 3 words 11,22,33 with ack echoing req after 5 cycles -> req_out toggles 3 times, data_out sequence 11,22,33, 3 done pulses, no errors.
REQ-031 Timeout: TIMEOUT_CYCLES=4, no ack -> timeout_err=1 after 4 WAIT_ACK cycles, state held; then ack toggles -> done pulse, timeout_err still 1.
REQ-032 Spurious ack: ack_in toggles in IDLE -> proto_err=1 two edges later, in_ready stays 1, req_out unchanged.
REQ-033 Reset mid-transfer: reset_ low asynchronously during WAIT_ACK with req_out=1 -> req_out=0, in_ready=1, data_out=0, flags 0 immediately (no clk edge needed).
REQ-034 Input stability: in_data changing every cycle during WAIT_ACK -> data_out unchanged until the next accepted word.
